// File: rtl/elevator_if.sv
// Controller <-> environment bundle: request handshake, floor counter link,
// door controls and status pulses. clk/reset stay outside the interface.
interface elevator_if;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_ready;
  logic [3:0] cur_floor;
  logic       cnt_enb;
  logic       cnt_up;
  logic       door_hold;
  logic       door_open;
  logic       arrived;
  logic       req_err;

  // Environment side: requester, floor counter and door button.
  modport master (
    output req_valid, req_floor, cur_floor, door_hold,
    input  req_ready, cnt_enb, cnt_up, door_open, arrived, req_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_floor, cur_floor, door_hold,
    output req_ready, cnt_enb, cnt_up, door_open, arrived, req_err
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller. Accepts one floor request at a time in IDLE,
// steers an external up/down floor counter until the target is reached, then
// holds the door open for a dwell period (extendable with door_hold).
module elevator_ctrl #(
  parameter int TOP_FLOOR   = 9,
  parameter int DOOR_CYCLES = 8
) (
  input logic      clk,
  input logic      reset,
  elevator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  localparam logic [3:0] TOP        = 4'(TOP_FLOOR);
  localparam logic [7:0] DWELL_INIT = 8'(DOOR_CYCLES - 1);

  state_t     state;
  logic [3:0] target;
  logic [7:0] dwell;
  logic       up;
  logic       door;
  logic       arr;
  logic       err;
  logic       enb;

  assign bus.req_ready = (state == IDLE);
  assign bus.cnt_up    = up;
  assign bus.door_open = door;
  assign bus.arrived   = arr;
  assign bus.req_err   = err;
  assign bus.cnt_enb   = enb;

  // Counter enable: step only while short of target and inside the shaft;
  // reset kills it in the same cycle so a move stops without waiting an edge.
  always_comb begin
    enb = 1'b0;
    if (!reset) begin
      unique case (state)
        UP:      enb = (bus.cur_floor < target) && (bus.cur_floor < TOP);
        DOWN:    enb = (bus.cur_floor > target) && (bus.cur_floor != 4'd0);
        default: enb = 1'b0;
      endcase
    end
  end

  // Main FSM with registered status outputs; arrived/req_err are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      target <= 4'd0;
      dwell  <= 8'd0;
      up     <= 1'b1;
      door   <= 1'b0;
      arr    <= 1'b0;
      err    <= 1'b0;
    end else begin
      arr <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_floor > TOP) begin
              err <= 1'b1;
            end else begin
              target <= bus.req_floor;
              if (bus.req_floor == bus.cur_floor) begin
                state <= DOOR;
                door  <= 1'b1;
                dwell <= DWELL_INIT;
                arr   <= 1'b1;
              end else if (bus.req_floor > bus.cur_floor) begin
                state <= UP;
                up    <= 1'b1;
              end else begin
                state <= DOWN;
                up    <= 1'b0;
              end
            end
          end
        end
        UP: begin
          if (bus.cur_floor == target) begin
            state <= DOOR;
            door  <= 1'b1;
            dwell <= DWELL_INIT;
            arr   <= 1'b1;
          end else if (bus.cur_floor == TOP) begin
            // Counter reports the top floor without reaching target: give up.
            state <= DOOR;
            door  <= 1'b1;
            dwell <= DWELL_INIT;
            err   <= 1'b1;
          end
        end
        DOWN: begin
          if (bus.cur_floor == target) begin
            state <= DOOR;
            door  <= 1'b1;
            dwell <= DWELL_INIT;
            arr   <= 1'b1;
          end else if (bus.cur_floor == 4'd0) begin
            state <= DOOR;
            door  <= 1'b1;
            dwell <= DWELL_INIT;
            err   <= 1'b1;
          end
        end
        DOOR: begin
          if (bus.door_hold) begin
            dwell <= DWELL_INIT;
          end else if (dwell == 8'd0) begin
            state <= IDLE;
            door  <= 1'b0;
          end else begin
            dwell <= dwell - 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a behavioural 4-bit floor counter
// that can be force-loaded to emulate a misbehaving counter.
module tb_elevator_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       ld;
  logic [3:0] ld_val;
  logic [3:0] q;
  int checks   = 0;
  int failures = 0;

  elevator_if bus();

  elevator_ctrl #(.TOP_FLOOR(9), .DOOR_CYCLES(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Downstream counter: one-cycle latency, steps on cnt_enb.
  always @(posedge clk) begin
    if (ld)               q <= ld_val;
    else if (bus.cnt_enb) q <= bus.cnt_up ? q + 4'd1 : q - 4'd1;
  end
  assign bus.cur_floor = q;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_q(input logic [3:0] v);
    ld = 1'b1; ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  // Present a request for one handshake edge, then scramble req_floor.
  task automatic request(input logic [3:0] f);
    bus.req_valid = 1'b1; bus.req_floor = f;
    tick();
    bus.req_valid = 1'b0; bus.req_floor = 4'hf;
  endtask

  // Observe cycles until the controller is ready again (bounded).
  task automatic run_to_idle(output int n, output int en, output int enup,
                             output int arr, output int dor, output int err,
                             output int first_arr);
    n = 0; en = 0; enup = 0; arr = 0; dor = 0; err = 0; first_arr = 0;
    while (!bus.req_ready && n < 100) begin
      if (n == 0) first_arr = int'(bus.arrived);
      en   += int'(bus.cnt_enb);
      enup += int'(bus.cnt_enb && bus.cnt_up);
      arr  += int'(bus.arrived);
      dor  += int'(bus.door_open);
      err  += int'(bus.req_err);
      tick();
      n++;
    end
  endtask

  initial begin
    int n, en, enup, arr, dor, err, fa;
    reset = 1'b1; ld = 1'b1; ld_val = 4'd0;
    bus.req_valid = 1'b0; bus.req_floor = 4'd0; bus.door_hold = 1'b0;
    tick(); tick();
    chk("rst_cnt_enb", int'(bus.cnt_enb), 0);
    chk("rst_door", int'(bus.door_open), 0);
    chk("rst_arrived", int'(bus.arrived), 0);
    chk("rst_req_err", int'(bus.req_err), 0);
    reset = 1'b0; ld = 1'b0;
    tick();
    chk("post_rst_ready", int'(bus.req_ready), 1);
    chk("post_rst_cnt_up", int'(bus.cnt_up), 1);
    chk("post_rst_door", int'(bus.door_open), 0);

    // 2 -> 5: 3 moving cycles + 1 detect, 8 door cycles.
    load_q(4'd2);
    request(4'd5);
    run_to_idle(n, en, enup, arr, dor, err, fa);
    chk("up_cycles", n, 12);
    chk("up_enb", en, 3);
    chk("up_enb_up", enup, 3);
    chk("up_q", int'(q), 5);
    chk("up_arrived", arr, 1);
    chk("up_door", dor, 8);
    chk("up_err", err, 0);

    // 7 -> 1: counting down, no overshoot.
    load_q(4'd7);
    request(4'd1);
    chk("dn_cnt_up", int'(bus.cnt_up), 0);
    run_to_idle(n, en, enup, arr, dor, err, fa);
    chk("dn_cycles", n, 15);
    chk("dn_enb", en, 6);
    chk("dn_enb_up", enup, 0);
    chk("dn_q", int'(q), 1);
    chk("dn_arrived", arr, 1);
    chk("dn_cnt_up_hold", int'(bus.cnt_up), 0);

    // 4 -> 4: straight to door, arrived in first door cycle.
    load_q(4'd4);
    request(4'd4);
    run_to_idle(n, en, enup, arr, dor, err, fa);
    chk("eq_cycles", n, 8);
    chk("eq_enb", en, 0);
    chk("eq_first_arrived", fa, 1);
    chk("eq_arrived", arr, 1);
    chk("eq_door", dor, 8);
    chk("eq_q", int'(q), 4);

    // Out-of-range request 12.
    request(4'd12);
    chk("bad_err", int'(bus.req_err), 1);
    chk("bad_ready", int'(bus.req_ready), 1);
    chk("bad_enb", int'(bus.cnt_enb), 0);
    chk("bad_door", int'(bus.door_open), 0);
    tick();
    chk("bad_err_pulse", int'(bus.req_err), 0);
    chk("bad_q", int'(q), 4);

    // Door hold for the first 20 door cycles -> 28 open cycles total.
    bus.door_hold = 1'b1;
    request(4'd4);
    dor = 0;
    for (int i = 0; i < 20; i++) begin
      dor += int'(bus.door_open);
      tick();
    end
    bus.door_hold = 1'b0;
    run_to_idle(n, en, enup, arr, dor, err, fa);
    chk("hold_tail", dor, 8);
    chk("hold_total", n + 20, 28);

    // Reset mid-move 0 -> 9 at Q=4.
    load_q(4'd0);
    request(4'd9);
    tick(); tick(); tick(); tick();
    chk("mid_q", int'(q), 4);
    chk("mid_enb", int'(bus.cnt_enb), 1);
    reset = 1'b1;
    #1;
    chk("rstmv_enb_same", int'(bus.cnt_enb), 0);
    tick();
    chk("rstmv_q", int'(q), 4);
    chk("rstmv_enb", int'(bus.cnt_enb), 0);
    chk("rstmv_arrived", int'(bus.arrived), 0);
    reset = 1'b0;
    tick();
    chk("rstmv_ready", int'(bus.req_ready), 1);
    chk("rstmv_q2", int'(q), 4);
    chk("rstmv_cnt_up", int'(bus.cnt_up), 1);
    chk("rstmv_enb2", int'(bus.cnt_enb), 0);

    // Counter jumps to top floor while going up to 6.
    load_q(4'd2);
    request(4'd6);
    load_q(4'd9);
    chk("top_enb", int'(bus.cnt_enb), 0);
    tick();
    chk("top_err", int'(bus.req_err), 1);
    chk("top_arrived", int'(bus.arrived), 0);
    chk("top_door", int'(bus.door_open), 1);
    run_to_idle(n, en, enup, arr, dor, err, fa);
    chk("top_done", int'(n < 100), 1);

    // Counter jumps to 0 while going down to 3.
    load_q(4'd7);
    request(4'd3);
    load_q(4'd0);
    chk("bot_enb", int'(bus.cnt_enb), 0);
    tick();
    chk("bot_err", int'(bus.req_err), 1);
    chk("bot_arrived", int'(bus.arrived), 0);
    chk("bot_door", int'(bus.door_open), 1);
    run_to_idle(n, en, enup, arr, dor, err, fa);
    chk("bot_done", int'(n < 100), 1);
    chk("bot_q", int'(q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter TOP_FLOOR, default 9: highest valid floor index (0..15).
REQ-002 Parameter DOOR_CYCLES, default 8: door-open dwell in clk cycles (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  floor request present.
REQ-006 req_floor  input  4  requested floor, unsigned.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 cur_floor  input  4  current floor, taken from the downstream 4-bit counter output Q.
REQ-009 cnt_enb  output  1  counter enable; counter steps one floor per clk while high.
REQ-010 cnt_up  output  1  counter direction/mode: 1 = count up, 0 = count down.
REQ-011 door_hold  input  1  obstruction/hold button; sampled only in DOOR.
REQ-012 door_open  output  1  door open indicator.
REQ-013 arrived  output  1  one-cycle pulse on reaching the target floor.
REQ-014 req_err  output  1  one-cycle pulse when an invalid request is rejected.

Function
REQ-015 FSM states: IDLE, UP, DOWN, DOOR; encoded in registers; no other reachable states.
REQ-016 req_ready = 1 only in IDLE; handshake completes on the edge where req_valid && req_ready.
REQ-017 On accept, req_floor SHALL be registered as target; later changes to req_floor are ignored.
REQ-018 Accept with req_floor > TOP_FLOOR: req_err = 1 next cycle, state stays IDLE, target unchanged.
REQ-019 Accept with req_floor == cur_floor: go to DOOR next cycle, arrived = 1 that cycle, no counter movement.
REQ-020 Accept with req_floor > cur_floor: go to UP; req_floor < cur_floor: go to DOWN.
REQ-021 cnt_enb is combinational: 1 in UP while cur_floor < target and cur_floor < TOP_FLOOR; 1 in DOWN while cur_floor > target and cur_floor != 0; else 0.
REQ-022 cnt_up = 1 in UP, 0 in DOWN, holds last value in IDLE/DOOR (reset value 1).
REQ-023 Counter latency is one cycle (Q updates on edge after cnt_enb sampled); controller never asserts cnt_enb when cur_floor == target, so no overshoot.
REQ-024 UP/DOWN -> DOOR on the edge where cur_floor == target is observed; arrived = 1 in the first DOOR cycle only.
REQ-025 Boundary: in UP with cur_floor == TOP_FLOOR != target, or DOWN with cur_floor == 0 != target, go to DOOR with arrived = 0 and req_err = 1 (out-of-range counter).
REQ-026 DOOR: door_open = 1; 8-bit dwell counter loads DOOR_CYCLES-1 on entry, decrements each cycle; DOOR -> IDLE on the edge after it reads 0.
REQ-027 door_hold = 1 in DOOR reloads dwell counter to DOOR_CYCLES-1; door stays open while held, indefinitely.
REQ-028 Moves take |target - cur_floor_at_accept| cycles in UP/DOWN plus one cycle for equality detection.
REQ-029 req_valid outside IDLE is ignored (not queued).

Reset
REQ-030 reset = 1 at a clk edge, in any state: next state IDLE, target = 0, dwell = 0, cnt_up = 1.
REQ-031 During and the cycle after reset: cnt_enb = 0, door_open = 0, arrived = 0, req_err = 0, req_ready = 1 once reset is low.
REQ-032 Reset mid-move stops the counter immediately (cnt_enb = 0 in the reset cycle); cur_floor is not restored.

Verification
REQ-033 cur_floor=2, request 5 -> cnt_enb/cnt_up high exactly 3 cycles, Q=5, arrived one pulse, door_open 8 cycles, then req_ready=1.
REQ-034 cur_floor=7, request 1 -> cnt_up=0, cnt_enb high 6 cycles, Q=1, no overshoot to 0.
REQ-035 cur_floor=4, request 4 -> DOOR next cycle, cnt_enb never high, arrived pulses.
REQ-036 Request 12 (TOP_FLOOR=9) -> req_err one pulse, state IDLE, cnt_enb stays 0.
REQ-037 In DOOR, door_hold high 20 cycles then low -> door_open high 20+8 cycles total.
REQ-038 Reset asserted mid-move from 0 to 9 at Q=4 -> cnt_enb=0 same cycle, Q stays 4, IDLE, req_ready=1 after reset.
